// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer: FSM states, power-up codes, tone table.
// Pure declarations; no logic, no latency.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_COOLDOWN = 3'd2,
        S_WIN      = 3'd3,
        S_LOSE     = 3'd4
    } state_t;

    localparam logic [1:0] PK_NONE = 2'd0;
    localparam logic [1:0] PK_HARM = 2'd1;
    localparam logic [1:0] PK_HEAL = 2'd2;
    localparam logic [1:0] PK_RSVD = 2'd3;

    localparam logic [12:0] HIT_FREQ     = 13'd500;
    localparam logic [5:0]  HIT_FRAMES   = 6'd60;
    localparam logic [12:0] SCORE_FREQ   = 13'd6500;
    localparam logic [5:0]  SCORE_FRAMES = 6'd5;

    localparam logic [9:0] SCORE_MAX = 10'd1023;

    function automatic logic [9:0] score_inc(input logic [9:0] s);
        return (s == SCORE_MAX) ? s : s + 10'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Player/collision inputs and score/lives/overlay/tone outputs of the game sequencer.
// Plain level/strobe signals; no handshake, no backpressure.
interface game_sequencer_if;
    logic        frame_tick;
    logic        start_in;
    logic        restart_in;
    logic        pipe_passed;
    logic        pipe_hit;
    logic        power_hit;
    logic [1:0]  power_kind;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        go_win;
    logic        go_lose;
    logic [12:0] buzz_freq;
    logic        buzz_on;

    modport master (
        output frame_tick, start_in, restart_in, pipe_passed, pipe_hit, power_hit, power_kind,
        input  score, lives, state, go_win, go_lose, buzz_freq, buzz_on
    );

    modport slave (
        input  frame_tick, start_in, restart_in, pipe_passed, pipe_hit, power_hit, power_kind,
        output score, lives, state, go_win, go_lose, buzz_freq, buzz_on
    );
endinterface

// File: rtl/game_sequencer_sound_arbiter.sv
// Buzzer arbiter: hit tone preempts everything, score tone only starts on silence.
// One-CLOCK load latency; duration counted in frames; events arriving while busy are dropped.
module sound_arbiter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        hit_evt,
    input  logic        score_evt,
    output logic [12:0] buzz_freq,
    output logic        buzz_on
);
    logic [5:0] buzz_time;

    always_ff @(posedge clk) begin
        if (reset) begin
            buzz_time <= '0;
            buzz_freq <= '0;
        end else if (hit_evt) begin
            buzz_time <= HIT_FRAMES;
            buzz_freq <= HIT_FREQ;
        end else if (score_evt && buzz_time == '0) begin
            buzz_time <= SCORE_FRAMES;
            buzz_freq <= SCORE_FREQ;
        end else if (frame_tick && buzz_time != '0) begin
            buzz_time <= buzz_time - 6'd1;
        end
    end

    assign buzz_on = (buzz_time != '0);
endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM: start/run/cooldown/win/lose, score and lives bookkeeping, tone requests.
// Transitions take effect on frame_tick CLOCKs (score on any CLOCK); inputs are never stalled.
module game_sequencer
    import game_pkg::*;
#(
    parameter int START_LIVES  = 2,
    parameter int MAX_LIVES    = 3,
    parameter int WIN_SCORE    = 37,
    parameter int HIT_COOLDOWN = 60
) (
    input  logic             CLOCK,
    input  logic             reset,
    game_sequencer_if.slave  bus
);
    localparam logic [1:0]  START_L = 2'(START_LIVES);
    localparam logic [1:0]  MAX_L   = 2'(MAX_LIVES);
    localparam logic [9:0]  WIN_S   = 10'(WIN_SCORE);
    localparam logic [15:0] CD_INIT = 16'(HIT_COOLDOWN);

    state_t      state_q, state_d;
    logic [9:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] cool_q, cool_d;
    logic        pipe_q, power_q;
    logic        pipe_rise, power_rise, playing, score_evt, hit_evt;

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state_q <= S_IDLE;
            score_q <= '0;
            lives_q <= START_L;
            cool_q  <= '0;
            pipe_q  <= 1'b0;
            power_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cool_q  <= cool_d;
            if (bus.frame_tick) begin
                pipe_q  <= bus.pipe_hit;
                power_q <= bus.power_hit;
            end
        end
    end

    // Edges are measured frame-to-frame, so a hit held across frames counts once.
    assign pipe_rise  = bus.frame_tick & bus.pipe_hit  & ~pipe_q;
    assign power_rise = bus.frame_tick & bus.power_hit & ~power_q;
    assign playing    = (state_q == S_RUN) || (state_q == S_COOLDOWN);
    assign score_evt  = playing && bus.pipe_passed && (score_q != SCORE_MAX);

    always_comb begin
        state_d = state_q;
        score_d = score_evt ? score_inc(score_q) : score_q;
        lives_d = lives_q;
        cool_d  = cool_q;
        hit_evt = 1'b0;
        if (bus.frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_in) begin
                        state_d = S_RUN;
                        score_d = '0;
                        lives_d = START_L;
                    end
                end
                S_RUN, S_COOLDOWN: begin
                    if (score_q >= WIN_S) begin
                        state_d = S_WIN;
                    end else if (state_q == S_RUN && pipe_rise) begin
                        hit_evt = 1'b1;
                        if (lives_q != '0) begin
                            lives_d = lives_q - 2'd1;
                            cool_d  = CD_INIT;
                            state_d = S_COOLDOWN;
                        end else begin
                            state_d = S_LOSE;
                        end
                    end else begin
                        if (state_q == S_COOLDOWN) begin
                            cool_d = (cool_q > 16'd1) ? cool_q - 16'd1 : '0;
                            if (cool_q <= 16'd1) state_d = S_RUN;
                        end
                        if (power_rise && bus.power_kind == PK_HEAL && lives_q < MAX_L)
                            lives_d = lives_q + 2'd1;
                        else if (power_rise && bus.power_kind == PK_HARM && lives_q != '0)
                            lives_d = lives_q - 2'd1;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (bus.restart_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.state   = state_q;
        bus.score   = score_q;
        bus.lives   = lives_q;
        bus.go_win  = (state_q == S_WIN);
        bus.go_lose = (state_q == S_LOSE);
    end

    sound_arbiter u_sound (
        .clk       (CLOCK),
        .reset     (reset),
        .frame_tick(bus.frame_tick),
        .hit_evt   (hit_evt),
        .score_evt (score_evt),
        .buzz_freq (bus.buzz_freq),
        .buzz_on   (bus.buzz_on)
    );
endmodule

// File: tb/tb_game_sequencer.sv
// Directed scenarios; expectations are queued as stimulus is applied and drained after each step.
module tb_game_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    string tag_q[$];
    int    sel_q[$];
    int    val_q[$];

    localparam int SEL_STATE = 0, SEL_SCORE = 1, SEL_LIVES = 2, SEL_BUZZ = 3,
                   SEL_FREQ = 4, SEL_WIN = 5, SEL_LOSE = 6;

    game_sequencer_if bus ();

    game_sequencer dut (
        .CLOCK(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_STATE: return int'(bus.state);
            SEL_SCORE: return int'(bus.score);
            SEL_LIVES: return int'(bus.lives);
            SEL_BUZZ:  return int'(bus.buzz_on);
            SEL_FREQ:  return int'(bus.buzz_freq);
            SEL_WIN:   return int'(bus.go_win);
            SEL_LOSE:  return int'(bus.go_lose);
            default:   return -1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        val_q.push_back(val);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            string t;
            int    s;
            int    v;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            v = val_q.pop_front();
            check(t, observe(s), v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pass_pipe();
        bus.pipe_passed = 1'b1;
        step();
        bus.pipe_passed = 1'b0;
    endtask

    task automatic power(input logic [1:0] kind);
        bus.power_kind = kind;
        bus.power_hit  = 1'b1;
        frame();
        bus.power_hit  = 1'b0;
        frame();
    endtask

    initial begin
        bus.frame_tick  = 1'b0;
        bus.start_in    = 1'b0;
        bus.restart_in  = 1'b0;
        bus.pipe_passed = 1'b0;
        bus.pipe_hit    = 1'b0;
        bus.power_hit   = 1'b0;
        bus.power_kind  = 2'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_val("rst_state", SEL_STATE, 0);
        expect_val("rst_score", SEL_SCORE, 0);
        expect_val("rst_lives", SEL_LIVES, 2);
        expect_val("rst_buzz", SEL_BUZZ, 0);
        expect_val("rst_freq", SEL_FREQ, 0);
        expect_val("rst_win", SEL_WIN, 0);
        expect_val("rst_lose", SEL_LOSE, 0);
        drain();

        // Start only happens on a frame tick
        bus.start_in = 1'b1;
        step();
        expect_val("start_no_tick", SEL_STATE, 0);
        drain();
        frame();
        bus.start_in = 1'b0;
        expect_val("start_state", SEL_STATE, 1);
        expect_val("start_lives", SEL_LIVES, 2);
        expect_val("start_score", SEL_SCORE, 0);
        drain();

        pass_pipe();
        expect_val("pass_score", SEL_SCORE, 1);
        expect_val("pass_buzz", SEL_BUZZ, 1);
        expect_val("pass_freq", SEL_FREQ, 6500);
        drain();

        bus.pipe_hit = 1'b1;
        frame();
        bus.pipe_hit = 1'b0;
        expect_val("hit_state", SEL_STATE, 2);
        expect_val("hit_lives", SEL_LIVES, 1);
        expect_val("hit_freq", SEL_FREQ, 500);
        expect_val("hit_buzz", SEL_BUZZ, 1);
        drain();
        frames(29);
        bus.pipe_hit = 1'b1;
        frame();
        bus.pipe_hit = 1'b0;
        expect_val("cd_hit30_state", SEL_STATE, 2);
        expect_val("cd_hit30_lives", SEL_LIVES, 1);
        drain();
        frames(29);
        expect_val("cd59_state", SEL_STATE, 2);
        expect_val("cd59_buzz", SEL_BUZZ, 1);
        expect_val("cd59_freq", SEL_FREQ, 500);
        drain();
        frame();
        expect_val("cd60_state", SEL_STATE, 1);
        expect_val("cd60_buzz", SEL_BUZZ, 0);
        drain();

        power(2'd3);
        expect_val("rsvd_lives", SEL_LIVES, 1);
        drain();
        power(2'd2);
        expect_val("heal1_lives", SEL_LIVES, 2);
        drain();
        power(2'd2);
        expect_val("heal2_lives", SEL_LIVES, 3);
        drain();
        power(2'd2);
        expect_val("heal_sat_lives", SEL_LIVES, 3);
        drain();

        // Simultaneous pipe hit and harm: only the pipe hit counts
        bus.pipe_hit   = 1'b1;
        bus.power_hit  = 1'b1;
        bus.power_kind = 2'd1;
        frame();
        bus.pipe_hit  = 1'b0;
        bus.power_hit = 1'b0;
        expect_val("both_state", SEL_STATE, 2);
        expect_val("both_lives", SEL_LIVES, 2);
        drain();
        frames(60);
        expect_val("both_back_run", SEL_STATE, 1);
        drain();

        power(2'd1);
        power(2'd1);
        expect_val("harm_to0_lives", SEL_LIVES, 0);
        drain();
        power(2'd1);
        expect_val("harm_at0_lives", SEL_LIVES, 0);
        expect_val("harm_at0_state", SEL_STATE, 1);
        drain();

        bus.pipe_hit = 1'b1;
        frame();
        bus.pipe_hit = 1'b0;
        expect_val("lose_state", SEL_STATE, 4);
        expect_val("lose_flag", SEL_LOSE, 1);
        expect_val("lose_win", SEL_WIN, 0);
        drain();
        pass_pipe();
        expect_val("lose_score_frozen", SEL_SCORE, 1);
        drain();
        bus.restart_in = 1'b1;
        frame();
        bus.restart_in = 1'b0;
        expect_val("restart_state", SEL_STATE, 0);
        expect_val("restart_lose", SEL_LOSE, 0);
        drain();

        bus.start_in = 1'b1;
        frame();
        bus.start_in = 1'b0;
        expect_val("restart_score0", SEL_SCORE, 0);
        expect_val("restart_lives", SEL_LIVES, 2);
        drain();
        for (int i = 0; i < 36; i++) pass_pipe();
        frame();
        expect_val("score36_state", SEL_STATE, 1);
        expect_val("score36", SEL_SCORE, 36);
        drain();
        pass_pipe();
        expect_val("score37_pre_tick", SEL_STATE, 1);
        drain();
        frame();
        expect_val("win_state", SEL_STATE, 3);
        expect_val("win_flag", SEL_WIN, 1);
        expect_val("win_score", SEL_SCORE, 37);
        drain();
        pass_pipe();
        expect_val("win_score_frozen", SEL_SCORE, 37);
        drain();

        bus.restart_in = 1'b1;
        frame();
        bus.restart_in = 1'b0;
        bus.start_in = 1'b1;
        frame();
        bus.start_in = 1'b0;
        pass_pipe();
        bus.pipe_hit = 1'b1;
        frame();
        bus.pipe_hit = 1'b0;
        expect_val("pre_rst_state", SEL_STATE, 2);
        expect_val("pre_rst_buzz", SEL_BUZZ, 1);
        drain();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_val("mid_rst_state", SEL_STATE, 0);
        expect_val("mid_rst_buzz", SEL_BUZZ, 0);
        expect_val("mid_rst_score", SEL_SCORE, 0);
        expect_val("mid_rst_lives", SEL_LIVES, 2);
        expect_val("mid_rst_freq", SEL_FREQ, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
